// File: rtl/timer_a_ccr_pkg.sv
// Shared definitions for the TIMER_A capture/compare stage: CCTL field
// positions, output-mode and capture-edge codes, and bus address decode.
package timer_a_pkg;

  typedef enum logic [2:0] {
    OM_OUTBIT  = 3'b000,
    OM_SET     = 3'b001,
    OM_TOGGLE  = 3'b010,
    OM_RESET   = 3'b011,
    OM_RST_SET = 3'b100,
    OM_SET_RST = 3'b101
  } outmod_e;

  localparam logic [1:0] CM_NONE = 2'b00;
  localparam logic [1:0] CM_RISE = 2'b01;
  localparam logic [1:0] CM_FALL = 2'b10;
  localparam logic [1:0] CM_BOTH = 2'b11;

  localparam int CCTL_CAP        = 0;
  localparam int CCTL_CM_LSB     = 1;
  localparam int CCTL_OUTMOD_LSB = 3;
  localparam int CCTL_OUT        = 6;
  localparam int CCTL_CCIE       = 7;

  // Even addresses are CCTLn, odd are CCRn; the channel is addr >> 1.
  function automatic int addr_chan(input int addr);
    return addr >> 1;
  endfunction

  function automatic logic addr_is_ccr(input int addr);
    return (addr % 2) == 1;
  endfunction

endpackage

// File: rtl/timer_a_ccr_chan.sv
// One capture/compare channel: CCTL/CCR registers, cci synchronizer and
// edge detect, waveform output and flags.
// Optional: TIMER_A_CCR_SHADOW_EN buffers compare-mode CCR writes in a
// shadow register that loads into the active CCR on the next zero event.
module timer_a_ccr_chan
  import timer_a_pkg::*;
#(
  parameter int TA_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [TA_W-1:0] i_ta,
  input  logic            i_step,
  input  logic            i_zero,
  input  logic            i_cci,
  input  logic            i_we_cctl,
  input  logic            i_we_ccr,
  input  logic [7:0]      i_wdata,
  input  logic            i_clr_ifg,
  output logic [7:0]      o_cctl,
  output logic [7:0]      o_ccr,
  output logic            o_out,
  output logic            o_ccifg,
  output logic            o_cov,
  output logic            o_irq
);

  logic [7:0]      cctl;
  logic [TA_W-1:0] ccr;
  logic [TA_W-1:0] ccr_vis;
  logic            sync1, sync2, prev;
  logic            cap, rise, fall, cap_evt, match;
  logic [1:0]      cm;
  outmod_e         outmod;

  assign cap    = cctl[CCTL_CAP];
  assign cm     = cctl[CCTL_CM_LSB +: 2];
  assign outmod = outmod_e'(cctl[CCTL_OUTMOD_LSB +: 3]);
  assign rise   = sync2 & ~prev;
  assign fall   = ~sync2 & prev;
  assign cap_evt = cap & ((rise & (cm == CM_RISE || cm == CM_BOTH)) |
                          (fall & (cm == CM_FALL || cm == CM_BOTH)));
  // Only a fresh count value can match, so a stalled timer never re-fires.
  assign match  = ~cap & i_step & (i_ta == ccr);

  // Two-flop synchronizer plus history flop for edge decode.
  always_ff @(posedge i_clk) begin
    if (i_rst) {sync1, sync2, prev} <= '0;
    else       {sync1, sync2, prev} <= {i_cci, sync1, sync2};
  end

  // Control register.
  always_ff @(posedge i_clk) begin
    if (i_rst)          cctl <= '0;
    else if (i_we_cctl) cctl <= i_wdata;
  end

`ifdef TIMER_A_CCR_SHADOW_EN
  logic [TA_W-1:0] shadow;

  // Capture loads both copies; compare-mode writes wait in the shadow
  // until the count wraps through zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ccr    <= '0;
      shadow <= '0;
    end else if (cap_evt) begin
      ccr    <= i_ta;
      shadow <= i_ta;
    end else begin
      if (i_we_ccr)             shadow <= i_wdata[TA_W-1:0];
      if (i_we_ccr && cap)      ccr    <= i_wdata[TA_W-1:0];
      else if (i_zero && !cap)  ccr    <= shadow;
    end
  end
  assign ccr_vis = shadow;
`else
  // Capture has priority over a same-cycle bus write.
  always_ff @(posedge i_clk) begin
    if (i_rst)         ccr <= '0;
    else if (cap_evt)  ccr <= i_ta;
    else if (i_we_ccr) ccr <= i_wdata[TA_W-1:0];
  end
  assign ccr_vis = ccr;
`endif

  // Interrupt flag: a set event beats a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (i_rst)                o_ccifg <= 1'b0;
    else if (match | cap_evt) o_ccifg <= 1'b1;
    else if (i_clr_ifg)       o_ccifg <= 1'b0;
  end

  // Overflow: capture on an unserviced flag; cleared by leaving capture mode.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                   o_cov <= 1'b0;
    else if (cap_evt && o_ccifg)                 o_cov <= 1'b1;
    else if (i_we_cctl && !i_wdata[CCTL_CAP])    o_cov <= 1'b0;
  end

  // Waveform output per OUTMOD; match wins over zero in the PWM modes.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_out <= 1'b0;
    else begin
      case (outmod)
        OM_SET:     if (match) o_out <= 1'b1;
        OM_TOGGLE:  if (match) o_out <= ~o_out;
        OM_RESET:   if (match) o_out <= 1'b0;
        OM_RST_SET: if (match) o_out <= 1'b0; else if (i_zero) o_out <= 1'b1;
        OM_SET_RST: if (match) o_out <= 1'b1; else if (i_zero) o_out <= 1'b0;
        default:    o_out <= cctl[CCTL_OUT];  // OM_OUTBIT and reserved codes
      endcase
    end
  end

  // Zero-extended readback of the visible CCR.
  always_comb begin
    o_ccr = '0;
    o_ccr[TA_W-1:0] = ccr_vis;
  end

  assign o_cctl = cctl;
  assign o_irq  = o_ccifg & cctl[CCTL_CCIE];

endmodule

// File: rtl/timer_a_ccr.sv
// TIMER_A capture/compare block: count step/zero detect, register bus
// decode and read mux, channel array, combined interrupt request.
// Optional: TIMER_A_CCR_SHADOW_EN (see timer_a_ccr_chan).
module timer_a_ccr
  import timer_a_pkg::*;
#(
  parameter  int N_CH = 2,
  parameter  int TA_W = 8,
  localparam int AW   = (N_CH == 1) ? 1 : $clog2(2 * N_CH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [TA_W-1:0] i_TA,
  input  logic [N_CH-1:0] i_cci,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [7:0]      i_wdata,
  input  logic [N_CH-1:0] i_clr_ifg,
  output logic [7:0]      o_rdata,
  output logic [N_CH-1:0] o_out,
  output logic [N_CH-1:0] o_ccifg,
  output logic [N_CH-1:0] o_cov,
  output logic            o_irq
);

  logic [TA_W-1:0]           ta_q;
  logic                      step, zero, is_ccr;
  int                        sel_ch;
  logic [N_CH-1:0][7:0]      cctl_rd, ccr_rd;
  logic [N_CH-1:0]           irq_req;

  // Previous count, so a held count produces no events.
  always_ff @(posedge i_clk) begin
    if (i_rst) ta_q <= '0;
    else       ta_q <= i_TA;
  end

  assign step   = (i_TA != ta_q);
  assign zero   = step & (i_TA == '0);
  assign sel_ch = addr_chan(int'(i_addr));
  assign is_ccr = addr_is_ccr(int'(i_addr));

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    timer_a_ccr_chan #(.TA_W(TA_W)) u_chan (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_ta      (i_TA),
      .i_step    (step),
      .i_zero    (zero),
      .i_cci     (i_cci[g]),
      .i_we_cctl (i_we && !is_ccr && sel_ch == g),
      .i_we_ccr  (i_we &&  is_ccr && sel_ch == g),
      .i_wdata   (i_wdata),
      .i_clr_ifg (i_clr_ifg[g]),
      .o_cctl    (cctl_rd[g]),
      .o_ccr     (ccr_rd[g]),
      .o_out     (o_out[g]),
      .o_ccifg   (o_ccifg[g]),
      .o_cov     (o_cov[g]),
      .o_irq     (irq_req[g])
    );
  end

  // Read mux; addresses beyond the last channel read as zero.
  always_comb begin
    o_rdata = '0;
    for (int n = 0; n < N_CH; n++)
      if (sel_ch == n) o_rdata = is_ccr ? ccr_rd[n] : cctl_rd[n];
  end

  assign o_irq = |irq_req;

endmodule
